flash_fetch_buffer: RTL and testbench

- Read-only fetch front-end for the on-chip flash Avalon-MM data port.
- Accepts 32-bit byte-addressed word requests from a fetch/test client, converts them to word addresses, and fills a single-line prefetch buffer with an Avalon burst read.
- Serves hits from the buffer and returns one 32-bit word per request.
- Sits directly upstream of the flash IP and downstream of the fetch client (LED/segment test harness or CPU IF stage).

---
 rtl/flash_fetch_pkg.sv | 18 +
 rtl/flash_line_buf.sv | 23 ++
 rtl/flash_fetch_buffer.sv | 150 +++++++++++++++
 tb/tb_flash_fetch_buffer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_fetch_pkg.sv
// Shared types and constants for the flash fetch front-end.
package flash_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FILL,
    RESP
  } state_e;

  localparam logic [31:0] ERR_DATA = 32'h0;

  // Width of the word offset inside a line; LINE_WORDS is a power of two >= 2.
  function automatic int line_off_w(input int line_words);
    return $clog2(line_words);
  endfunction

endpackage

// File: rtl/flash_line_buf.sv
// Single prefetch line: LINE_WORDS x 32 register array, one write port, one async read port.
module flash_line_buf #(
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [LINE_WORDS];

  // NOTE: storage has no reset; the top's line_valid flag decides whether contents are usable.
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/flash_fetch_buffer.sv
// Read-only fetch front-end: single-line prefetch buffer filled by Avalon-MM burst reads from flash.
module flash_fetch_buffer
  import flash_fetch_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int LINE_WORDS  = 4,
  parameter int BC_W        = 4,
  parameter int FLASH_WORDS = 16384
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] avm_addr,
  output logic              avm_read,
  output logic [BC_W-1:0]   avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  input  logic [31:0]       avm_readdata
);

  localparam int OFF_W = line_off_w(LINE_WORDS);
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  state_e state, state_nxt;

  logic              line_valid;
  logic [TAG_W-1:0]  tag;
  logic [OFF_W-1:0]  beat_cnt;
  logic              flush_pend;
  logic [ADDR_W-1:0] req_waddr_q;
  logic [ADDR_W-1:0] avm_addr_q;
  logic [31:0]       resp_data_q;
  logic              resp_err_q;

  logic [ADDR_W-1:0] waddr;
  logic              addr_err;
  logic              accept;
  logic              hit;
  logic              beat_take;
  logic              last_beat;
  logic [31:0]       buf_rd_data;

  assign waddr    = req_addr[ADDR_W+1:2];
  assign addr_err = (req_addr[1:0] != 2'b00)
                 || (req_addr[31:ADDR_W+2] != '0)
                 || (32'(waddr) >= 32'(FLASH_WORDS));
  assign accept   = req_valid && (state == IDLE);
  assign hit      = line_valid && (tag == waddr[ADDR_W-1:OFF_W]);

  // A beat can land in the very cycle the burst command is accepted.
  assign beat_take = avm_readdatavalid
                  && ((state == FILL) || ((state == ISSUE) && !avm_waitrequest));
  assign last_beat = beat_take && (beat_cnt == LAST_BEAT);

  flash_line_buf #(
    .LINE_WORDS(LINE_WORDS),
    .IDX_W     (OFF_W)
  ) u_line_buf (
    .clk    (clk),
    .we     (beat_take),
    .wr_idx (beat_cnt),
    .wr_data(avm_readdata),
    .rd_idx (waddr[OFF_W-1:0]),
    .rd_data(buf_rd_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = (addr_err || hit) ? RESP : ISSUE;
      end
      ISSUE: begin
        if (!avm_waitrequest) state_nxt = last_beat ? RESP : FILL;
      end
      FILL: begin
        if (last_beat) state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every register here uses <= so all updates see the pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      line_valid  <= 1'b0;
      tag         <= '0;
      beat_cnt    <= '0;
      flush_pend  <= 1'b0;
      req_waddr_q <= '0;
      avm_addr_q  <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      if (flush && ((state == IDLE) || (state == RESP))) line_valid <= 1'b0;
      if (flush && ((state == ISSUE) || (state == FILL))) flush_pend <= 1'b1;

      // Hit/error are judged on the pre-flush line even if flush arrives with the request.
      if (accept) begin
        req_waddr_q <= waddr;
        resp_err_q  <= addr_err;
        if (addr_err) begin
          resp_data_q <= ERR_DATA;
        end else if (hit) begin
          resp_data_q <= buf_rd_data;
        end else begin
          avm_addr_q <= {waddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
      end

      if (beat_take) begin
        beat_cnt <= beat_cnt + OFF_W'(1);
        if (beat_cnt == req_waddr_q[OFF_W-1:0]) resp_data_q <= avm_readdata;
      end

      // A flush seen anywhere during the burst leaves the freshly filled line invalid.
      if (last_beat) begin
        beat_cnt   <= '0;
        line_valid <= !(flush_pend || flush);
        tag        <= req_waddr_q[ADDR_W-1:OFF_W];
        flush_pend <= 1'b0;
      end
    end
  end

  assign req_ready      = (state == IDLE);
  assign resp_valid     = (state == RESP);
  assign resp_data      = resp_data_q;
  assign resp_err       = resp_err_q;
  assign avm_read       = (state == ISSUE);
  assign avm_addr       = avm_addr_q;
  assign avm_burstcount = BC_W'(LINE_WORDS);

endmodule

// File: tb/tb_flash_fetch_buffer.sv
// Self-checking bench: flash burst model, cycle-level reference model and directed requests.
module tb_flash_fetch_buffer;

  localparam int ADDR_W      = 14;
  localparam int LINE_WORDS  = 4;
  localparam int BC_W        = 4;
  localparam int FLASH_WORDS = 16384;

  logic              clk;
  logic              resetn;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic [ADDR_W-1:0] avm_addr;
  logic              avm_read;
  logic [BC_W-1:0]   avm_burstcount;
  logic              avm_waitrequest;
  logic              avm_readdatavalid;
  logic [31:0]       avm_readdata;

  flash_fetch_buffer #(
    .ADDR_W     (ADDR_W),
    .LINE_WORDS (LINE_WORDS),
    .BC_W       (BC_W),
    .FLASH_WORDS(FLASH_WORDS)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .flush            (flush),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .resp_err         (resp_err),
    .avm_addr         (avm_addr),
    .avm_read         (avm_read),
    .avm_burstcount   (avm_burstcount),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata     (avm_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] flash_word(input int unsigned w);
    case (w)
      0:       return 32'h0000_0011;
      1:       return 32'h0000_0022;
      2:       return 32'h0000_0033;
      3:       return 32'h0000_0044;
      default: return 32'hF1A5_0000 | 32'(w);
    endcase
  endfunction

  // ---------------- flash IP model ----------------
  int          wait_cfg = 2;
  bit          lat0     = 0;
  bit          gap_mode = 0;
  bit          gap_pat [7] = '{1, 0, 0, 1, 1, 0, 1};
  int          gap_idx  = 0;
  int          wcnt     = 0;
  int          bursts   = 0;
  logic [31:0] last_burst_addr = '0;
  logic [31:0] last_burst_bc   = '0;
  logic [31:0] beat_q [$];

  initial begin
    bit new_burst;
    bit go;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(posedge clk);
      #1;
      new_burst = 0;
      if (avm_read) begin
        if (wcnt < wait_cfg) begin
          avm_waitrequest = 1'b1;
          wcnt++;
        end else begin
          avm_waitrequest = 1'b0;
          wcnt            = 0;
          new_burst       = 1;
          bursts++;
          last_burst_addr = 32'(avm_addr);
          last_burst_bc   = 32'(avm_burstcount);
          gap_idx         = 0;
          for (int i = 0; i < int'(avm_burstcount); i++)
            beat_q.push_back(flash_word(32'(avm_addr) + 32'(i)));
        end
      end else begin
        avm_waitrequest = 1'b0;
        wcnt            = 0;
      end
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'hDEAD_BEEF;
      if (beat_q.size() > 0 && (!new_burst || lat0)) begin
        go = 1;
        if (gap_mode) begin
          go = gap_pat[gap_idx % 7];
          gap_idx++;
        end
        if (go) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = beat_q.pop_front();
        end
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  int          cyc      = 0;
  int          resp_at  = -1;
  int          acc_cyc  = 0;
  int          m_line   = 0;
  int          line_base = 0;
  int          beats_seen = 0;
  bit          busy     = 0;
  bit          miss_out = 0;
  bit          cmd_done = 0;
  bit          m_valid  = 0;
  bit          poison   = 0;
  logic [31:0] exp_data = '0;
  bit          exp_err  = 0;

  always @(negedge clk) begin
    bit          rdy_exp;
    bit          fl_idle;
    bit          exp_rd;
    bit          err;
    int unsigned wa;
    cyc++;
    if (!resetn) begin
      busy = 0; miss_out = 0; cmd_done = 0; beats_seen = 0;
      m_valid = 0; poison = 0; resp_at = -1;
    end else begin
      rdy_exp = !busy;
      check("req_ready", 32'(req_ready), 32'(rdy_exp));
      check("resp_valid", 32'(resp_valid), 32'(cyc == resp_at));
      if (cyc == resp_at) begin
        check("resp_data", resp_data, exp_data);
        check("resp_err", 32'(resp_err), 32'(exp_err));
        busy = 0;
      end
      exp_rd = miss_out && !cmd_done && (cyc > acc_cyc);
      check("avm_read", 32'(avm_read), 32'(exp_rd));
      if (avm_read) begin
        check("avm_addr", 32'(avm_addr), 32'(line_base));
        check("avm_burstcount", 32'(avm_burstcount), 32'(LINE_WORDS));
      end

      fl_idle = flush && !miss_out;
      if (flush && miss_out) poison = 1;

      if (miss_out && (cyc > acc_cyc) && avm_read && !avm_waitrequest) cmd_done = 1;
      if (miss_out && cmd_done && avm_readdatavalid) begin
        beats_seen++;
        if (beats_seen == LINE_WORDS) begin
          m_valid  = !poison;
          m_line   = line_base / LINE_WORDS;
          poison   = 0;
          miss_out = 0;
          resp_at  = cyc + 1;
        end
      end

      if (req_valid && rdy_exp) begin
        acc_cyc = cyc;
        busy    = 1;
        wa      = 32'(req_addr[ADDR_W+1:2]);
        err     = (req_addr[1:0] != 0) || (req_addr[31:ADDR_W+2] != 0) || (wa >= FLASH_WORDS);
        if (err) begin
          exp_err  = 1;
          exp_data = 32'h0;
          resp_at  = cyc + 1;
        end else begin
          exp_err  = 0;
          exp_data = flash_word(wa);
          if (m_valid && (m_line == int'(wa / LINE_WORDS))) begin
            resp_at = cyc + 1;
          end else begin
            miss_out   = 1;
            cmd_done   = 0;
            beats_seen = 0;
            line_base  = int'(wa / LINE_WORDS) * LINE_WORDS;
          end
        end
      end
      if (fl_idle) m_valid = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input logic [31:0] a, input bit fl,
                        output logic [31:0] d, output logic e, output int lat);
    bit acc;
    acc = 0;
    lat = -1;
    d   = 'x;
    e   = 1'bx;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = a;
    flush     = fl;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) acc = 1;
    end
    if (!acc) begin
      check("req_accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      flush     = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i;
        d   = resp_data;
        e   = resp_err;
        break;
      end
    end
    if (lat < 0) check("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    int          b0;
    bit          seen;

    resetn    = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_avm_read", 32'(avm_read), 32'd0);
    check("rst_avm_addr", 32'(avm_addr), 32'd0);
    check("rst_avm_burstcount", 32'(avm_burstcount), 32'd4);
    resetn = 1'b1;

    // First miss with two waitrequest cycles.
    wait_cfg = 2;
    b0 = bursts;
    do_req(32'h0000_0000, 0, d, e, lat);
    check("t1_data", d, 32'h11);
    check("t1_err", 32'(e), 32'd0);
    check("t1_bursts", 32'(bursts - b0), 32'd1);
    check("t1_burst_addr", last_burst_addr, 32'd0);
    check("t1_burst_bc", last_burst_bc, 32'd4);

    // Hit in the same line.
    wait_cfg = 0;
    b0 = bursts;
    do_req(32'h0000_0008, 0, d, e, lat);
    check("t2_data", d, 32'h33);
    check("t2_lat", 32'(lat), 32'd1);
    check("t2_bursts", 32'(bursts - b0), 32'd0);

    // Errors: misaligned and out of range.
    b0 = bursts;
    do_req(32'h0000_0006, 0, d, e, lat);
    check("t3_mis_err", 32'(e), 32'd1);
    check("t3_mis_data", d, 32'd0);
    check("t3_mis_lat", 32'(lat), 32'd1);
    do_req(32'h0001_0000, 0, d, e, lat);
    check("t3_oor_err", 32'(e), 32'd1);
    check("t3_oor_data", d, 32'd0);
    check("t3_bursts", 32'(bursts - b0), 32'd0);

    // Flush during FILL: response delivered, line left invalid.
    b0 = bursts;
    fork
      do_req(32'h0000_0010, 0, d, e, lat);
      begin
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(posedge clk);
          #2;
          if (bursts > b0) seen = 1;
        end
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
      end
    join
    check("t4_data", d, 32'hF1A5_0004);
    b0 = bursts;
    do_req(32'h0000_0010, 0, d, e, lat);
    check("t4_refetch_bursts", 32'(bursts - b0), 32'd1);
    check("t4_refetch_addr", last_burst_addr, 32'd4);
    check("t4_refetch_data", d, 32'hF1A5_0004);

    // Readdatavalid gaps 1,0,0,1,1,0,1.
    gap_mode = 1;
    do_req(32'h0000_0024, 0, d, e, lat);
    check("t5_data", d, 32'hF1A5_0009);
    gap_mode = 0;
    do_req(32'h0000_002C, 0, d, e, lat);
    check("t5_hit_last", d, 32'hF1A5_000B);
    check("t5_hit_lat", 32'(lat), 32'd1);

    // First beat in the same cycle the command is accepted.
    lat0 = 1;
    do_req(32'h0000_003C, 0, d, e, lat);
    check("t6_data", d, 32'hF1A5_000F);
    lat0 = 0;
    do_req(32'h0000_0030, 0, d, e, lat);
    check("t6_hit_first", d, 32'hF1A5_000C);

    // Flush coincident with acceptance: hit on old line, then miss.
    b0 = bursts;
    do_req(32'h0000_0034, 1, d, e, lat);
    check("t7_flush_hit_data", d, 32'hF1A5_000D);
    check("t7_flush_hit_lat", 32'(lat), 32'd1);
    do_req(32'h0000_0038, 0, d, e, lat);
    check("t7_after_flush_bursts", 32'(bursts - b0), 32'd1);

    // Last valid flash word.
    do_req(32'h0000_FFFC, 0, d, e, lat);
    check("t8_last_data", d, 32'hF1A5_3FFF);
    check("t8_last_err", 32'(e), 32'd0);
    check("t8_last_addr", last_burst_addr, 32'd16380);

    // Reset during FILL; stale beats arrive while idle.
    gap_mode = 1;
    b0 = bursts;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = 32'h0000_0000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #2;
      if (bursts > b0) seen = 1;
    end
    check("t9_burst_started", 32'(seen), 32'd1);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("t9_rst_ready", 32'(req_ready), 32'd1);
    check("t9_rst_read", 32'(avm_read), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (12) @(posedge clk);
    gap_mode = 0;
    b0 = bursts;
    do_req(32'h0000_0004, 0, d, e, lat);
    check("t9_fresh_bursts", 32'(bursts - b0), 32'd1);
    check("t9_fresh_addr", last_burst_addr, 32'd0);
    check("t9_fresh_data", d, 32'h22);
    do_req(32'h0000_000C, 0, d, e, lat);
    check("t9_hit_data", d, 32'h44);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
